qeciphy_frame_scheduler: RTL

- Sequences the TX framing strobes that drive qeciphy_crc_compute: one FAW slot per frame, then CRC_GROUPS groups of DATA_PER_CRC data slots, each group closed by one CRC slot.
- Default frame is 64 slots: slot 0 FAW, CRC slots 7,14,...,63, all others data.
- Checks that the CRC engine's crc_valid returns with the expected latency and flags misalignment.
- Sits between link-control (enable) and the CRC/TX mux datapath.

---
 rtl/qeciphy_frame_scheduler.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/qeciphy_frame_scheduler.sv
// qeciphy_frame_scheduler
// Generates the TX framing strobes (FAW / CRC / data) for the CRC engine and
// checks that crc_valid_i comes back CRC_LAT cycles after each CRC slot.
// Frame layout: slot 0 is FAW, followed by CRC_GROUPS groups of DATA_PER_CRC
// data slots, each group closed by one CRC slot.
module qeciphy_frame_scheduler #(
  parameter int DATA_PER_CRC = 6,
  parameter int CRC_GROUPS   = 9,
  parameter int CRC_LAT      = 1,
  localparam int FRAME_LEN   = 1 + CRC_GROUPS * (DATA_PER_CRC + 1),
  localparam int SW          = $clog2(FRAME_LEN)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          enable_i,
  input  logic          crc_valid_i,
  input  logic          clr_err_i,
  output logic          faw_boundary_o,
  output logic          crc_boundary_o,
  output logic          data_slot_o,
  output logic [SW-1:0] slot_idx_o,
  output logic [3:0]    group_idx_o,
  output logic          running_o,
  output logic [15:0]   frame_count_o,
  output logic          crc_align_err_o
);

  localparam int KW = $clog2(DATA_PER_CRC + 1);
  localparam logic [SW-1:0] LAST_SLOT = SW'(FRAME_LEN - 1);
  localparam logic [KW-1:0] K_CRC     = KW'(DATA_PER_CRC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_n;
  logic [SW-1:0]       slot_q, slot_n;
  logic [KW-1:0]       k_q, k_n;       // position inside current CRC group
  logic [3:0]          grp_q, grp_n;
  logic [15:0]         fcnt_q, fcnt_n;
  logic                faw_q, faw_n;
  logic                crc_q, crc_n;
  logic                data_q, data_n;
  logic                run_q, run_n;
  logic [CRC_LAT-1:0]  pipe_q, pipe_n;
  logic                err_q, err_n;
  logic                wrap;
  logic                advance;
  logic                mismatch;

  // Next-state, slot counters and registered-strobe precomputation
  always_comb begin
    state_n = state_q;
    slot_n  = '0;
    k_n     = '0;
    grp_n   = '0;
    fcnt_n  = fcnt_q;
    advance = 1'b0;
    wrap    = (slot_q == LAST_SLOT);

    case (state_q)
      IDLE: begin
        if (enable_i) state_n = RUN;
      end
      RUN: begin
        advance = 1'b1;
        if (wrap)           state_n = enable_i ? RUN : IDLE;
        else if (!enable_i) state_n = DRAIN;
      end
      DRAIN: begin
        advance = 1'b1;
        if (wrap)          state_n = enable_i ? RUN : IDLE;
        else if (enable_i) state_n = RUN;
      end
      default: state_n = IDLE;
    endcase

    // Group/sub-slot counters track the slot index so no divider is needed;
    // a wrap leaves all counters at zero, which is both the FAW slot and IDLE.
    if (advance && !wrap) begin
      slot_n = slot_q + 1'b1;
      if (slot_q == '0) begin
        k_n   = '0;
        grp_n = '0;
      end else if (k_q == K_CRC) begin
        k_n   = '0;
        grp_n = grp_q + 4'd1;
      end else begin
        k_n   = k_q + 1'b1;
        grp_n = grp_q;
      end
    end
    if (advance && wrap) fcnt_n = fcnt_q + 16'd1;

    run_n  = (state_n != IDLE);
    faw_n  = run_n && (slot_n == '0);
    crc_n  = run_n && (slot_n != '0) && (k_n == K_CRC);
    data_n = run_n && !faw_n && !crc_n;
  end

  // Alignment checker: expected crc_valid is crc_boundary delayed CRC_LAT cycles
  always_comb begin
    pipe_n   = CRC_LAT'({pipe_q, crc_q});
    mismatch = (crc_valid_i != pipe_q[CRC_LAT-1]);
    err_n    = mismatch | (err_q & ~clr_err_i);
  end

  // State, counters, strobes and sticky error registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      slot_q  <= '0;
      k_q     <= '0;
      grp_q   <= '0;
      fcnt_q  <= '0;
      faw_q   <= 1'b0;
      crc_q   <= 1'b0;
      data_q  <= 1'b0;
      run_q   <= 1'b0;
      pipe_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      slot_q  <= slot_n;
      k_q     <= k_n;
      grp_q   <= grp_n;
      fcnt_q  <= fcnt_n;
      faw_q   <= faw_n;
      crc_q   <= crc_n;
      data_q  <= data_n;
      run_q   <= run_n;
      pipe_q  <= pipe_n;
      err_q   <= err_n;
    end
  end

  assign faw_boundary_o  = faw_q;
  assign crc_boundary_o  = crc_q;
  assign data_slot_o     = data_q;
  assign slot_idx_o      = slot_q;
  assign group_idx_o     = grp_q;
  assign running_o       = run_q;
  assign frame_count_o   = fcnt_q;
  assign crc_align_err_o = err_q;

endmodule
